// File: rtl/audio_seq_pkg.sv
// Shared types, note constants and default melody for the note sequencer.
// Used by audio_seq_rom and audio_note_seq (option macro: AUDIO_NOTE_SEQ_LOOP_EN).
package audio_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_PLAY = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    typedef struct packed {
        logic [15:0] freq;
        logic [3:0]  dur;
    } note_t;

    localparam logic [15:0] NOTE_A4   = 16'd4723;
    localparam logic [15:0] NOTE_C5   = 16'd5617;
    localparam logic [15:0] NOTE_E5   = 16'd7077;
    localparam logic [15:0] NOTE_REST = 16'd0;

    // Sixteen-entry tune; larger tables repeat it.
    function automatic note_t melody(input logic [3:0] idx);
        note_t n;
        case (idx)
            4'd0:    n = '{NOTE_A4,   4'd2};
            4'd1:    n = '{NOTE_C5,   4'd1};
            4'd2:    n = '{NOTE_E5,   4'd0};
            4'd3:    n = '{NOTE_REST, 4'd3};
            4'd4:    n = '{NOTE_A4,   4'd1};
            4'd5:    n = '{NOTE_C5,   4'd2};
            4'd6:    n = '{NOTE_E5,   4'd1};
            4'd7:    n = '{NOTE_A4,   4'd1};
            4'd8:    n = '{NOTE_C5,   4'd1};
            4'd9:    n = '{NOTE_E5,   4'd2};
            4'd10:   n = '{NOTE_REST, 4'd1};
            4'd11:   n = '{NOTE_A4,   4'd1};
            4'd12:   n = '{NOTE_C5,   4'd1};
            4'd13:   n = '{NOTE_E5,   4'd1};
            4'd14:   n = '{NOTE_A4,   4'd2};
            default: n = '{NOTE_C5,   4'd4};
        endcase
        return n;
    endfunction

endpackage

// File: rtl/audio_seq_rom.sv
// Synchronous-read note table holding the default melody.
// Part of audio_note_seq (option macro: AUDIO_NOTE_SEQ_LOOP_EN).
module audio_seq_rom
    import audio_seq_pkg::*;
#(
    parameter int NUM_STEPS = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [$clog2(NUM_STEPS)-1:0] addr_i,
    output note_t                        data_o
);

    note_t data_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
        end else begin
            data_q <= melody(4'(addr_i));
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/audio_note_seq.sv
// Note-table sequencer driving a wave generator's frequency word and gate.
// Define AUDIO_NOTE_SEQ_LOOP_EN to add loop_i for endless playback.
module audio_note_seq
    import audio_seq_pkg::*;
#(
    parameter int NUM_STEPS = 16,
    parameter int FREQ_W    = 16,
    parameter int TEMPO_W   = 24
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start_i,
    input  logic                         stop_i,
`ifdef AUDIO_NOTE_SEQ_LOOP_EN
    input  logic                         loop_i,
`endif
    input  logic [TEMPO_W-1:0]           tempo_div_i,
    output logic [FREQ_W-1:0]            freq_o,
    output logic                         gate_o,
    output logic [$clog2(NUM_STEPS)-1:0] step_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int SW = $clog2(NUM_STEPS);
    localparam logic [SW-1:0] LAST = SW'(NUM_STEPS - 1);

    state_e              state_q, state_d;
    logic [SW-1:0]       step_q, step_d;
    logic [TEMPO_W-1:0]  tempo_q, tempo_d;
    logic [TEMPO_W-1:0]  cnt_q, cnt_d;
    logic [3:0]          nt_q, nt_d;
    note_t               note_q, note_d;
    logic [FREQ_W-1:0]   freq_q, freq_d;
    logic                gate_q, gate_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    note_t rom_q;
    note_t note_cur;
    logic  tick;
    logic  loop_w;
    logic [3:0] dur_last;

`ifdef AUDIO_NOTE_SEQ_LOOP_EN
    assign loop_w = loop_i;
`else
    assign loop_w = 1'b0;
`endif

    // Addressed with the next step so the entry is ready during LOAD.
    audio_seq_rom #(
        .NUM_STEPS(NUM_STEPS)
    ) u_rom (
        .clk   (clk),
        .rstn  (rstn),
        .addr_i(step_d),
        .data_o(rom_q)
    );

    assign tick     = (cnt_q == tempo_q);
    assign note_cur = (state_q == S_LOAD) ? rom_q : note_q;
    assign dur_last = (note_q.dur == 4'd0) ? 4'd0 : note_q.dur - 4'd1;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        tempo_d = tempo_q;
        nt_d    = nt_q;
        note_d  = note_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    step_d  = '0;
                    tempo_d = tempo_div_i;
                end
            end
            S_LOAD: begin
                note_d  = rom_q;
                nt_d    = '0;
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (tick) begin
                    if (nt_q == dur_last) state_d = S_GAP;
                    else nt_d = nt_q + 4'd1;
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (step_q != LAST) begin
                        step_d  = step_q + SW'(1);
                        state_d = S_LOAD;
                    end else if (loop_w) begin
                        step_d  = '0;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                step_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                step_d  = '0;
                state_d = S_IDLE;
            end
        endcase
        if (stop_i) begin
            state_d = S_IDLE;
            step_d  = '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q + TEMPO_W'(1);
        if (tick || state_d != state_q ||
            !(state_q == S_PLAY || state_q == S_GAP)) begin
            cnt_d = '0;
        end
    end

    // LOAD keeps the previous word so the generator never glitches to 0.
    always_comb begin
        freq_d = '0;
        gate_d = 1'b0;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        unique case (state_d)
            S_PLAY: begin
                freq_d = FREQ_W'(note_cur.freq);
                gate_d = (note_cur.freq != 16'd0);
            end
            S_GAP:   freq_d = FREQ_W'(note_cur.freq);
            S_LOAD:  freq_d = freq_q;
            default: freq_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            tempo_q <= '0;
            cnt_q   <= '0;
            nt_q    <= '0;
            note_q  <= '0;
            freq_q  <= '0;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            tempo_q <= tempo_d;
            cnt_q   <= cnt_d;
            nt_q    <= nt_d;
            note_q  <= note_d;
            freq_q  <= freq_d;
            gate_q  <= gate_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign freq_o = freq_q;
    assign gate_o = gate_q;
    assign step_o = step_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_audio_note_seq.sv
// Scoreboard bench for audio_note_seq: per-cycle expected trace plus corner sequences.
// Define AUDIO_NOTE_SEQ_LOOP_EN to also exercise loop_i.
module tb_audio_note_seq;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        loop_i = 1'b0;
    logic [23:0] tempo_div_i = '0;
    logic [15:0] freq_o;
    logic        gate_o;
    logic [3:0]  step_o;
    logic        busy_o;
    logic        done_o;

    always #40 clk = ~clk;

    audio_note_seq #(
        .NUM_STEPS(16),
        .FREQ_W   (16),
        .TEMPO_W  (24)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start_i    (start_i),
        .stop_i     (stop_i),
`ifdef AUDIO_NOTE_SEQ_LOOP_EN
        .loop_i     (loop_i),
`endif
        .tempo_div_i(tempo_div_i),
        .freq_o     (freq_o),
        .gate_o     (gate_o),
        .step_o     (step_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    typedef struct packed {
        logic [15:0] f;
        logic        g;
        logic [3:0]  s;
        logic        b;
        logic        d;
    } obs_t;

    typedef struct {
        int tempo;
        int busy_cycles;
    } vec_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   prev_f = 0;
    int   mel_f[16] = '{4723, 5617, 7077, 0, 4723, 5617, 7077, 4723,
                        5617, 7077, 0, 4723, 5617, 7077, 4723, 5617};
    int   mel_d[16] = '{2, 1, 0, 3, 1, 2, 1, 1, 1, 2, 1, 1, 1, 1, 2, 4};
    obs_t zero_obs;

    function automatic obs_t cur();
        obs_t o;
        o = '{freq_o, gate_o, step_o, busy_o, done_o};
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got f=%0d g=%0b s=%0d b=%0b d=%0b want f=%0d g=%0b s=%0d b=%0b d=%0b",
                     name, act.f, act.g, act.s, act.b, act.d,
                     exp.f, exp.g, exp.s, exp.b, exp.d);
        end
    endtask

    task automatic push(input int f, input int g, input int s, input int b, input int d);
        obs_t o;
        o = '{16'(f), 1'(g), 4'(s), 1'(b), 1'(d)};
        exp_q.push_back(o);
    endtask

    task automatic push_pass(input int t);
        int f;
        int n;
        for (int s = 0; s < 16; s++) begin
            push(prev_f, 0, s, 1, 0);
            f = mel_f[s];
            n = ((mel_d[s] == 0) ? 1 : mel_d[s]) * (t + 1);
            for (int k = 0; k < n; k++) push(f, (f != 0) ? 1 : 0, s, 1, 0);
            for (int k = 0; k <= t; k++) push(f, 0, s, 1, 0);
            prev_f = f;
        end
    endtask

    task automatic drain(input string name, output int busy_cnt);
        obs_t e;
        busy_cnt = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            busy_cnt += int'(busy_o);
            check(name, cur(), e);
        end
    endtask

    // Tempo is scrambled after the start edge to prove it was latched.
    task automatic pulse_start(input int t);
        @(posedge clk);
        #1;
        tempo_div_i = 24'(t);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        tempo_div_i = 24'(7 + $urandom_range(0, 5));
    endtask

    task automatic wait_for(input string name, input int step, input int gate,
                            input int freq, output bit found);
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (int'(step_o) == step && int'(gate_o) == gate && int'(freq_o) == freq)
                found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: target state not reached, got s=%0d g=%0b f=%0d",
                     name, step_o, gate_o, freq_o);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        int   busy_cnt;
        bit   found;

        zero_obs = '0;
        vecs[0] = '{3, 181};
        vecs[1] = '{0, 58};
        vecs[2] = '{1, 99};
        vecs[3] = '{2, 140};

        #100;
        @(negedge clk);
        check("reset", cur(), zero_obs);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("idle", cur(), zero_obs);

        for (int v = 0; v < 4; v++) begin
            prev_f = 0;
            push_pass(vecs[v].tempo);
            push(0, 0, 15, 1, 1);
            push(0, 0, 0, 0, 0);
            pulse_start(vecs[v].tempo);
            drain($sformatf("run_t%0d", vecs[v].tempo), busy_cnt);
            checks++;
            if (busy_cnt != vecs[v].busy_cycles) begin
                errors++;
                $display("FAIL busy_len_t%0d: got %0d want %0d",
                         vecs[v].tempo, busy_cnt, vecs[v].busy_cycles);
            end
        end

        pulse_start(3);
        wait_for("seek_step5", 5, 1, 5617, found);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        check("stop_idle", cur(), zero_obs);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stop_hold", cur(), zero_obs);
        end
        stop_i = 1'b1;
        start_i = 1'b1;
        tempo_div_i = 24'd0;
        @(negedge clk);
        stop_i = 1'b0;
        start_i = 1'b0;
        check("stop_start", cur(), zero_obs);
        @(negedge clk);
        check("stop_start2", cur(), zero_obs);

        pulse_start(2);
        wait_for("seek_gap1", 1, 0, 5617, found);
        #5 rstn = 1'b0;
        #1 check("rst_async", cur(), zero_obs);
        @(posedge clk);
        #1 rstn = 1'b1;
        prev_f = 0;
        push_pass(0);
        push(0, 0, 15, 1, 1);
        push(0, 0, 0, 0, 0);
        pulse_start(0);
        drain("after_rst", busy_cnt);
        checks++;
        if (busy_cnt != 58) begin
            errors++;
            $display("FAIL busy_len_rst: got %0d want 58", busy_cnt);
        end

`ifdef AUDIO_NOTE_SEQ_LOOP_EN
        loop_i = 1'b1;
        prev_f = 0;
        for (int l = 0; l < 3; l++) push_pass(1);
        push(prev_f, 0, 0, 1, 0);
        pulse_start(1);
        drain("loop", busy_cnt);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        loop_i = 1'b0;
        check("loop_stop", cur(), zero_obs);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
